mux_n_pipe: RTL
===============

Name: mux_n_pipe

Overview:
- Parametrised, registered successor to the datapath N-way selectors.
- Selects one of N_IN words of WIDTH bits, flags out-of-range selects and carries the result through a 2-entry elastic buffer with valid/ready handshake.
- Sits between multicycle-datapath sources (PC, ALUOut, MDR, shift result, constants) and sinks that may stall, e.g. a memory write port or a register-file write stage.
- Replaces fixed 32-bit, 7-input combinational selectors where back-pressure or a registered output is needed.

Parameters:
- WIDTH, 32, data word width in bits.
- N_IN, 7, number of data inputs (2..2**SEL_W).
- SEL_W, 3, selector width; must satisfy 2**SEL_W >= N_IN.
- DEFAULT_VAL, 0, word output for any selector >= N_IN.
- CNT_W, 8, width of the out-of-range event counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- in_bus  in  N_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- selector  in  SEL_W  input index, sampled on accept.
- in_valid  in  1  producer has a selection request.
- in_ready  out  1  block can accept this cycle.
- flush  in  1  synchronous discard of buffered entries.
- out  out  WIDTH  selected word at buffer head.
- out_sel_err  out  1  head entry came from an out-of-range selector.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- err_count  out  CNT_W  saturating count of accepted out-of-range selects.

Behaviour:
- Reset (reset_n=0 at a rising clk edge):
  - Buffer emptied; out_valid=0; out=0; out_sel_err=0; err_count=0.
  - in_ready is 0 while reset_n=0 and 1 in the first cycle after release.
  - Reset mid-transfer drops all entries, with no partial output.
- Accept: in_valid && in_ready at an edge.
  - The block writes {word, err} into the buffer.
  - word = in_bus[selector] if selector < N_IN, else DEFAULT_VAL.
  - err = (selector >= N_IN).
  - Selection and in_bus are sampled only on the accepting edge; later changes do not affect stored data.
- Latency: an accepted entry appears on out/out_valid the cycle after acceptance (1 cycle), if the buffer was empty.
- Buffer: 2 entries, FIFO order, implemented as a skid pair.
  - States: EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
  - in_ready = (state != FULL), driven from a register (no combinational path from out_ready).
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> FULL; pop without accept -> EMPTY; accept with pop -> ONE (new entry becomes head next cycle).
  - FULL: pop -> ONE (second entry moves to head); no accept possible.
- Pop: out_valid && out_ready.
  - out and out_sel_err stay stable while out_valid=1 and out_ready=0.
  - When empty, out holds the last popped value; do not rely on it.
- Throughput: 1 entry/cycle sustained when out_ready is held 1.
- flush=1 at an edge:
  - State -> EMPTY, out_valid=0 next cycle.
  - An accept in the same cycle is discarded, although in_ready was 1.
  - err_count is not cleared by flush.
  - flush has priority over accept and pop.
- err_count:
  - Increments by 1 per accepted out-of-range select, including ones later flushed.
  - Saturates at 2**CNT_W-1, with no wrap.
  - Cleared only by reset.
- Elaboration check: N_IN > 2**SEL_W or N_IN < 2 is an error (generate-time $error/invalid instance).

Decomposition:
- Shared package/header `datapath_defs`:
  - WORD_W=32.
  - Default DEFAULT_VAL=0.
  - Named selector constants for existing datapath selectors.
- Natural sub-module `skid_buf_2`, generic WIDTH+1 two-entry valid/ready buffer. It is reusable for other stalled datapath paths.
- The select/err/counter logic stays in mux_n_pipe.

Test Plan:
- Reset then basic select: in_bus k = 32'h1000_0000+k, N_IN=7, selector=5, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out=32'h1000_0005, out_valid=1, out_sel_err=0; following cycle out_valid=0.
- Out-of-range: selector=7 accepted -> out=32'h0, out_sel_err=1, err_count=1; 300 such accepts with CNT_W=8 -> err_count=255.
- Back-pressure: out_ready=0, accept selectors 1,2 -> in_ready=0 after the second accept, out stays 32'h1000_0001; set out_ready=1 -> pops 1 then 2 on consecutive cycles, in_ready returns to 1.
- Streaming: selector 0..6 on 7 consecutive cycles, out_ready=1 -> outputs 0..6 in order on 7 consecutive cycles, with no bubbles.
- Flush: buffer FULL, assert flush with in_valid=1, selector=3 -> next cycle out_valid=0 and the entry with selector 3 is never output; err_count unchanged.
- Mid-op reset: FULL buffer, reset_n=0 for 1 edge -> out_valid=0, out=0, err_count=0; in_ready=1 the cycle after release.

Source files
------------

// File: rtl/datapath_defs.sv
// Shared datapath constants: word width, default select word and the selector
// codes used by the multicycle datapath sources.
package datapath_defs;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] DEFAULT_VAL = '0;

    // Source indices on the datapath selector inputs.
    typedef enum logic [2:0] {
        SelPc       = 3'd0,
        SelAluOut   = 3'd1,
        SelMdr      = 3'd2,
        SelShift    = 3'd3,
        SelConst4   = 3'd4,
        SelImm      = 3'd5,
        SelImmShl2  = 3'd6
    } dp_sel_e;

    localparam int unsigned DP_NUM_SEL = 7;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/skid_buf_2.sv
// Generic two-entry FIFO-ordered valid/ready buffer; in_ready is registered so
// there is no combinational path from out_ready_i back to the producer.
module skid_buf_2
    import datapath_defs::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    skid_state_e      state_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic push;
    logic pop;

    assign push = in_valid_i && in_ready_q;
    assign pop  = out_valid_q && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StEmpty;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush_i) begin
            // Head data is left in place; only occupancy is discarded.
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        head_q      <= in_data_i;
                        state_q     <= StOne;
                        out_valid_q <= 1'b1;
                    end
                end
                StOne: begin
                    if (push && !pop) begin
                        tail_q     <= in_data_i;
                        state_q    <= StFull;
                        in_ready_q <= 1'b0;
                    end else if (push && pop) begin
                        head_q <= in_data_i;
                    end else if (pop) begin
                        state_q     <= StEmpty;
                        out_valid_q <= 1'b0;
                    end
                end
                StFull: begin
                    if (pop) begin
                        head_q     <= tail_q;
                        state_q    <= StOne;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StEmpty;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_data_o  = head_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-way word selector: flags out-of-range selects, counts them, and
// hands {err, word} to a two-entry elastic buffer with valid/ready handshake.
module mux_n_pipe
    import datapath_defs::*;
#(
    parameter int unsigned WIDTH              = datapath_defs::WORD_W,
    parameter int unsigned N_IN               = 7,
    parameter int unsigned SEL_W              = 3,
    parameter logic [WIDTH-1:0] DEFAULT_VAL   = WIDTH'(datapath_defs::DEFAULT_VAL),
    parameter int unsigned CNT_W              = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]      selector,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out,
    output logic                  out_sel_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      err_count
);

    if (N_IN < 2 || N_IN > (2 ** SEL_W)) begin : g_bad_params
        $error("mux_n_pipe: N_IN must be in 2..2**SEL_W");
    end

    localparam logic [SEL_W:0] NInW = (SEL_W + 1)'(N_IN);

    logic [WIDTH-1:0] sel_word;
    logic             sel_err;
    logic             buf_in_ready;
    logic             accept;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] err_count_d;

    always_comb begin
        sel_word = DEFAULT_VAL;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (selector == SEL_W'(k)) begin
                sel_word = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_err = ({1'b0, selector} >= NInW);

    // Gate with reset so the producer sees not-ready for the whole reset window.
    assign in_ready = buf_in_ready && reset_n;
    assign accept   = in_valid && in_ready;

    // Counts every accepted bad select, even one discarded by a same-cycle flush.
    always_comb begin
        err_count_d = err_count_q;
        if (accept && sel_err && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;

    skid_buf_2 #(
        .WIDTH (WIDTH + 1)
    ) u_skid_buf (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .flush_i     (flush),
        .in_data_i   ({sel_err, sel_word}),
        .in_valid_i  (in_valid),
        .in_ready_o  (buf_in_ready),
        .out_data_o  ({out_sel_err, out}),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

endmodule
